// File: rtl/descriptor_sequencer.sv
// -----------------------------------------------------------------------------
// descriptor_sequencer
//
// Walks a keypoint list held in BRAM. For each keypoint it decodes the octave
// field, places a GRIDxGRID window of SUBxSUB subpatches around the keypoint
// and clamps that window inside the octave's image. It then asks one shared
// external histogram engine for each subpatch, in raster order, and writes each
// returned histogram to the descriptor BRAM.
// Keypoints with a bad octave or out-of-image coordinates are counted and
// skipped. A pass stops early if the descriptor BRAM would overflow. A
// histogram request that never completes parks the block in ERROR.
//
// Ports
//   clk, rst_in_n      clock, asynchronous active-low reset
//   start              begin a pass (only honoured while idle)
//   key_read_addr      keypoint BRAM address
//   keypoint_read      {octave, x, y, level}; all-zero word ends the list
//   hist_start         one-cycle request to the histogram engine
//   hist_x, hist_y     subpatch top-left corner, octave-native coordinates
//   hist_octave        octave select for the request
//   hist_level         level select for the request
//   hist_done          one-cycle completion from the histogram engine
//   hist_data          histogram result, valid with hist_done
//   desc_write_addr    descriptor BRAM address
//   desc_wea           descriptor BRAM write enable
//   desc_out           descriptor BRAM write data
//   busy               high whenever not idle
//   descriptors_done   one-cycle end-of-pass pulse
//   error, error_code  sticky error flag; code 1 = timeout, 2 = capacity
//   kp_processed       keypoints described this pass (saturating)
//   kp_skipped         keypoints rejected this pass (saturating)
// -----------------------------------------------------------------------------
module descriptor_sequencer #(
  parameter int DIMENSION          = 64,
  parameter int NUM_OCTAVES        = 3,
  parameter int NUMBER_KEYPOINTS   = 1000,
  parameter int NUMBER_DESCRIPTORS = 4000,
  parameter int GRID               = 2,
  parameter int SUB                = 2,
  parameter int HIST_W             = 24,
  parameter int KP_READ_LATENCY    = 2,
  parameter int TIMEOUT_CYCLES     = 1024,
  localparam int COORD_W = $clog2(DIMENSION),
  localparam int OCT_W   = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1,
  localparam int KA_W    = $clog2(NUMBER_KEYPOINTS),
  localparam int DA_W    = $clog2(NUMBER_DESCRIPTORS),
  localparam int KP_W    = OCT_W + 2*COORD_W + 1
) (
  input  logic                clk,
  input  logic                rst_in_n,
  input  logic                start,
  output logic [KA_W-1:0]     key_read_addr,
  input  logic [KP_W-1:0]     keypoint_read,
  output logic                hist_start,
  output logic [COORD_W-1:0]  hist_x,
  output logic [COORD_W-1:0]  hist_y,
  output logic [OCT_W-1:0]    hist_octave,
  output logic                hist_level,
  input  logic                hist_done,
  input  logic [HIST_W-1:0]   hist_data,
  output logic [DA_W-1:0]     desc_write_addr,
  output logic                desc_wea,
  output logic [HIST_W-1:0]   desc_out,
  output logic                busy,
  output logic                descriptors_done,
  output logic                error,
  output logic [1:0]          error_code,
  output logic [15:0]         kp_processed,
  output logic [15:0]         kp_skipped
);

  localparam int WIN    = GRID * SUB;
  localparam int NPATCH = GRID * GRID;
  localparam int P_W    = (NPATCH > 1) ? $clog2(NPATCH) : 1;
  // One extra bit so the write pointer can reach NUMBER_DESCRIPTORS itself
  // when that depth is a power of two.
  localparam int DC_W   = $clog2(NUMBER_DESCRIPTORS + 1);
  localparam int FC_W   = $clog2(KP_READ_LATENCY + 1);
  localparam int WC_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t              state_reg, state_next;
  logic [KA_W-1:0]     key_addr_reg, key_addr_next;
  logic [DC_W-1:0]     desc_cnt_reg, desc_cnt_next;
  logic [FC_W-1:0]     fetch_cnt_reg, fetch_cnt_next;
  logic [WC_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic [P_W-1:0]      patch_reg, patch_next;
  logic [COORD_W-1:0]  ox_reg, ox_next;
  logic [COORD_W-1:0]  oy_reg, oy_next;
  logic [OCT_W-1:0]    oct_reg, oct_next;
  logic                level_reg, level_next;
  logic [HIST_W-1:0]   desc_out_reg, desc_out_next;
  logic                error_reg, error_next;
  logic [1:0]          error_code_reg, error_code_next;
  logic [15:0]         kp_proc_reg, kp_proc_next;
  logic [15:0]         kp_skip_reg, kp_skip_next;

  // Keypoint word fields.
  logic [OCT_W-1:0]    kp_oct;
  logic [COORD_W-1:0]  kp_x;
  logic [COORD_W-1:0]  kp_y;
  logic                kp_level;

  assign kp_oct   = keypoint_read[KP_W-1 -: OCT_W];
  assign kp_x     = keypoint_read[2*COORD_W -: COORD_W];
  assign kp_y     = keypoint_read[COORD_W -: COORD_W];
  assign kp_level = keypoint_read[0];

  // Per-patch offsets from the window origin, raster order.
  logic [COORD_W-1:0]  col_off [NPATCH];
  logic [COORD_W-1:0]  row_off [NPATCH];

  generate
    for (genvar gi = 0; gi < NPATCH; gi++) begin : g_patch_off
      assign col_off[gi] = COORD_W'((gi % GRID) * SUB);
      assign row_off[gi] = COORD_W'((gi / GRID) * SUB);
    end
  endgenerate

  // Window origin centred on the keypoint, pushed back inside [0, side-WIN].
  // Evaluated in a wide signed type so a keypoint near the top-left corner
  // produces a negative intermediate rather than wrapping.
  function automatic logic [COORD_W-1:0] window_origin(
    input logic [COORD_W-1:0] centre,
    input int                 side
  );
    int org;
    org = int'(centre) - WIN/2;
    if (org > side - WIN) org = side - WIN;
    if (org < 0)          org = 0;
    return COORD_W'(org);
  endfunction

  int   kp_side;
  logic advance;

  always_comb begin
    state_next      = state_reg;
    key_addr_next   = key_addr_reg;
    desc_cnt_next   = desc_cnt_reg;
    fetch_cnt_next  = fetch_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    patch_next      = patch_reg;
    ox_next         = ox_reg;
    oy_next         = oy_reg;
    oct_next        = oct_reg;
    level_next      = level_reg;
    desc_out_next   = desc_out_reg;
    error_next      = error_reg;
    error_code_next = error_code_reg;
    kp_proc_next    = kp_proc_reg;
    kp_skip_next    = kp_skip_reg;
    advance         = 1'b0;
    kp_side         = DIMENSION >> kp_oct;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          key_addr_next   = '0;
          desc_cnt_next   = '0;
          fetch_cnt_next  = '0;
          kp_proc_next    = '0;
          kp_skip_next    = '0;
          error_next      = 1'b0;
          error_code_next = 2'd0;
          state_next      = S_FETCH;
        end
      end

      S_FETCH: begin
        // The address has been stable since entry; wait out the BRAM pipeline.
        if (fetch_cnt_reg == FC_W'(KP_READ_LATENCY - 1)) begin
          state_next = S_DECODE;
        end else begin
          fetch_cnt_next = fetch_cnt_reg + FC_W'(1);
        end
      end

      S_DECODE: begin
        if (keypoint_read == '0) begin
          state_next = S_DONE;
        end else if ((int'(kp_oct) >= NUM_OCTAVES) ||
                     (int'(kp_x) >= kp_side) || (int'(kp_y) >= kp_side)) begin
          if (kp_skip_reg != 16'hFFFF) kp_skip_next = kp_skip_reg + 16'd1;
          advance = 1'b1;
        end else if ((int'(desc_cnt_reg) + NPATCH) > NUMBER_DESCRIPTORS) begin
          error_next      = 1'b1;
          error_code_next = 2'd2;
          state_next      = S_DONE;
        end else begin
          oct_next   = kp_oct;
          level_next = kp_level;
          ox_next    = window_origin(kp_x, kp_side);
          oy_next    = window_origin(kp_y, kp_side);
          patch_next = '0;
          state_next = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wait_cnt_next = '0;
        state_next    = S_WAIT;
      end

      S_WAIT: begin
        if (hist_done) begin
          desc_out_next = hist_data;
          state_next    = S_WRITE;
        end else if (wait_cnt_reg == WC_W'(TIMEOUT_CYCLES - 1)) begin
          error_next      = 1'b1;
          error_code_next = 2'd1;
          state_next      = S_ERROR;
        end else begin
          wait_cnt_next = wait_cnt_reg + WC_W'(1);
        end
      end

      S_WRITE: begin
        // The write strobe is this cycle; the pointer moves on at the edge.
        desc_cnt_next = desc_cnt_reg + DC_W'(1);
        if (patch_reg != P_W'(NPATCH - 1)) begin
          patch_next = patch_reg + P_W'(1);
          state_next = S_ISSUE;
        end else begin
          if (kp_proc_reg != 16'hFFFF) kp_proc_next = kp_proc_reg + 16'd1;
          advance = 1'b1;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      S_ERROR: begin
        // Terminal until reset; the engine may be wedged.
        state_next = S_ERROR;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Step to the next keypoint, ending the pass at the last BRAM entry.
    if (advance) begin
      if (key_addr_reg == KA_W'(NUMBER_KEYPOINTS - 1)) begin
        state_next = S_DONE;
      end else begin
        key_addr_next  = key_addr_reg + KA_W'(1);
        fetch_cnt_next = '0;
        state_next     = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_reg      <= S_IDLE;
      key_addr_reg   <= '0;
      desc_cnt_reg   <= '0;
      fetch_cnt_reg  <= '0;
      wait_cnt_reg   <= '0;
      patch_reg      <= '0;
      ox_reg         <= '0;
      oy_reg         <= '0;
      oct_reg        <= '0;
      level_reg      <= 1'b0;
      desc_out_reg   <= '0;
      error_reg      <= 1'b0;
      error_code_reg <= 2'd0;
      kp_proc_reg    <= '0;
      kp_skip_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      key_addr_reg   <= key_addr_next;
      desc_cnt_reg   <= desc_cnt_next;
      fetch_cnt_reg  <= fetch_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      patch_reg      <= patch_next;
      ox_reg         <= ox_next;
      oy_reg         <= oy_next;
      oct_reg        <= oct_next;
      level_reg      <= level_next;
      desc_out_reg   <= desc_out_next;
      error_reg      <= error_next;
      error_code_reg <= error_code_next;
      kp_proc_reg    <= kp_proc_next;
      kp_skip_reg    <= kp_skip_next;
    end
  end

  // Request coordinates derive from registers that only change in DECODE and
  // WRITE, so they hold steady for the whole ISSUE/WAIT handshake.
  assign key_read_addr    = key_addr_reg;
  assign hist_start       = (state_reg == S_ISSUE);
  assign hist_x           = ox_reg + col_off[patch_reg];
  assign hist_y           = oy_reg + row_off[patch_reg];
  assign hist_octave      = oct_reg;
  assign hist_level       = level_reg;
  assign desc_write_addr  = desc_cnt_reg[DA_W-1:0];
  assign desc_wea         = (state_reg == S_WRITE);
  assign desc_out         = desc_out_reg;
  assign busy             = (state_reg != S_IDLE);
  assign descriptors_done = (state_reg == S_DONE);
  assign error            = error_reg;
  assign error_code       = error_code_reg;
  assign kp_processed     = kp_proc_reg;
  assign kp_skipped       = kp_skip_reg;

endmodule

// File: tb/tb_descriptor_sequencer.sv
// -----------------------------------------------------------------------------
// tb_descriptor_sequencer
//
// Two sequencer instances: "a" with default parameters and "b" with a
// six-entry descriptor BRAM for the capacity case. Each has a keypoint BRAM
// model with two cycles of read latency and a histogram stub whose reply
// encodes the request, so every descriptor word is predictable.
// Expected requests and writes are queued by the stimulus; monitors pop and
// compare whenever the design presents a request or a write.
// -----------------------------------------------------------------------------
module tb_descriptor_sequencer;

  localparam int KW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // ---------------- instance a ----------------
  logic            start_a;
  logic [9:0]      kra_a;
  logic [KW-1:0]   kp_p1_a = '0, kp_p2_a = '0;
  logic            hs_a;
  logic [5:0]      hx_a, hy_a;
  logic [1:0]      ho_a;
  logic            hl_a;
  logic            hd_a = 1'b0;
  logic [23:0]     hdat_a = '0;
  logic [11:0]     dwa_a;
  logic            we_a;
  logic [23:0]     dout_a;
  logic            busy_a, done_a, err_a;
  logic [1:0]      ec_a;
  logic [15:0]     kpp_a, kps_a;

  descriptor_sequencer dut_a (
    .clk(clk), .rst_in_n(rst_n), .start(start_a),
    .key_read_addr(kra_a), .keypoint_read(kp_p2_a),
    .hist_start(hs_a), .hist_x(hx_a), .hist_y(hy_a),
    .hist_octave(ho_a), .hist_level(hl_a),
    .hist_done(hd_a), .hist_data(hdat_a),
    .desc_write_addr(dwa_a), .desc_wea(we_a), .desc_out(dout_a),
    .busy(busy_a), .descriptors_done(done_a),
    .error(err_a), .error_code(ec_a),
    .kp_processed(kpp_a), .kp_skipped(kps_a)
  );

  // ---------------- instance b ----------------
  logic            start_b;
  logic [9:0]      kra_b;
  logic [KW-1:0]   kp_p1_b = '0, kp_p2_b = '0;
  logic            hs_b;
  logic [5:0]      hx_b, hy_b;
  logic [1:0]      ho_b;
  logic            hl_b;
  logic            hd_b = 1'b0;
  logic [23:0]     hdat_b = '0;
  logic [2:0]      dwa_b;
  logic            we_b;
  logic [23:0]     dout_b;
  logic            busy_b, done_b, err_b;
  logic [1:0]      ec_b;
  logic [15:0]     kpp_b, kps_b;

  descriptor_sequencer #(.NUMBER_DESCRIPTORS(6)) dut_b (
    .clk(clk), .rst_in_n(rst_n), .start(start_b),
    .key_read_addr(kra_b), .keypoint_read(kp_p2_b),
    .hist_start(hs_b), .hist_x(hx_b), .hist_y(hy_b),
    .hist_octave(ho_b), .hist_level(hl_b),
    .hist_done(hd_b), .hist_data(hdat_b),
    .desc_write_addr(dwa_b), .desc_wea(we_b), .desc_out(dout_b),
    .busy(busy_b), .descriptors_done(done_b),
    .error(err_b), .error_code(ec_b),
    .kp_processed(kpp_b), .kp_skipped(kps_b)
  );

  // ---------------- keypoint BRAM models ----------------
  logic [KW-1:0] kp_mem_a [16];
  logic [KW-1:0] kp_mem_b [16];
  logic [KW-1:0] fill_word;

  function automatic logic [KW-1:0] lookup_a(input logic [9:0] a);
    if (a < 10'd16) return kp_mem_a[a[3:0]];
    return fill_word;
  endfunction

  function automatic logic [KW-1:0] lookup_b(input logic [9:0] a);
    if (a < 10'd16) return kp_mem_b[a[3:0]];
    return '0;
  endfunction

  always @(posedge clk) begin
    kp_p1_a <= lookup_a(kra_a);
    kp_p2_a <= kp_p1_a;
    kp_p1_b <= lookup_b(kra_b);
    kp_p2_b <= kp_p1_b;
  end

  function automatic logic [KW-1:0] kp(input int o, input int x, input int y, input int l);
    return {2'(o), 6'(x), 6'(y), 1'(l)};
  endfunction

  // ---------------- histogram stubs (not tied to DUT reset) ----------------
  int hlat     = 3;
  bit withhold = 1'b0;
  int cnt_a    = 0;
  int cnt_b    = 0;

  always @(posedge clk) begin
    hd_a <= 1'b0;
    if (hs_a && !withhold) begin
      cnt_a  <= hlat;
      hdat_a <= {hx_a, hy_a, ho_a, hl_a, 9'h15A};
    end else if (cnt_a > 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) hd_a <= 1'b1;
    end
  end

  always @(posedge clk) begin
    hd_b <= 1'b0;
    if (hs_b) begin
      cnt_b  <= 2;
      hdat_b <= {hx_b, hy_b, ho_b, hl_b, 9'h15A};
    end else if (cnt_b > 0) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) hd_b <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic [1:0] o;
    logic       l;
  } hreq_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [23:0] data;
  } wr_t;

  hreq_t hq_a [$];
  wr_t   wq_a [$];
  wr_t   wq_b [$];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt_a = 0, wr_cnt_a = 0;
  int done_cnt_b = 0, hs_cnt_b = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_hist(input int x, input int y, input int o, input int l);
    hreq_t h;
    h.x = 6'(x); h.y = 6'(y); h.o = 2'(o); h.l = 1'(l);
    hq_a.push_back(h);
  endtask

  task automatic expect_patch(input int x, input int y, input int o, input int l, input int addr);
    wr_t w;
    expect_hist(x, y, o, l);
    w.addr = 12'(addr);
    w.data = {6'(x), 6'(y), 2'(o), 1'(l), 9'h15A};
    wq_a.push_back(w);
  endtask

  hreq_t mon_h;
  wr_t   mon_w;
  wr_t   mon_wb;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hs_a) begin
        $display("[TB] a hist_req x=%0d y=%0d oct=%0d lvl=%0d", hx_a, hy_a, ho_a, hl_a);
        if (hq_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL hist_req_unexpected: got x=%0d y=%0d, required none", hx_a, hy_a);
        end else begin
          mon_h = hq_a.pop_front();
          chk_w("hist_req", 128'({hx_a, hy_a, ho_a, hl_a}), 128'(mon_h));
        end
      end
      if (we_a) begin
        wr_cnt_a++;
        $display("[TB] a desc_write addr=%0d data=%06h", dwa_a, dout_a);
        if (wq_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL desc_write_unexpected: got addr=%0d, required none", dwa_a);
        end else begin
          mon_w = wq_a.pop_front();
          chk_w("desc_write", 128'({dwa_a, dout_a}), 128'(mon_w));
        end
      end
      if (done_a) done_cnt_a++;

      if (hs_b) hs_cnt_b++;
      if (we_b) begin
        $display("[TB] b desc_write addr=%0d data=%06h", dwa_b, dout_b);
        if (wq_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_desc_write_unexpected: got addr=%0d, required none", dwa_b);
        end else begin
          mon_wb = wq_b.pop_front();
          chk_w("b_desc_write", 128'({9'd0, dwa_b, dout_b}), 128'(mon_wb));
        end
      end
      if (done_b) done_cnt_b++;
    end
  end

  function automatic logic [127:0] outs_a();
    return {28'd0, kra_a, hs_a, hx_a, hy_a, ho_a, hl_a, dwa_a, we_a, dout_a,
            busy_a, done_a, err_a, ec_a, kpp_a, kps_a};
  endfunction

  task automatic run_pass_a(input int budget, output int got);
    got = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge clk);
      if (done_a) got = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int got, d0, w0;
    wr_t wb;
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0; fill_word = '0;
    for (int i = 0; i < 16; i++) begin kp_mem_a[i] = '0; kp_mem_b[i] = '0; end
    #3 rst_n = 1'b0;
    #20;
    chk_w("reset_outputs", outs_a(), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy_a), 0);

    // 1: centred window, octave 0, level 1
    kp_mem_a[0] = kp(0, 10, 20, 1); kp_mem_a[1] = '0;
    expect_patch(8, 18, 0, 1, 0);  expect_patch(10, 18, 0, 1, 1);
    expect_patch(8, 20, 0, 1, 2);  expect_patch(10, 20, 0, 1, 3);
    d0 = done_cnt_a;
    run_pass_a(300, got);
    chk("t1_done_seen", got, 1);
    repeat (3) @(negedge clk);
    chk("t1_done_pulses", done_cnt_a - d0, 1);
    chk("t1_kp_processed", int'(kpp_a), 1);
    chk("t1_kp_skipped", int'(kps_a), 0);
    chk("t1_queues_empty", hq_a.size() + wq_a.size(), 0);
    chk("t1_busy", int'(busy_a), 0);
    chk("t1_error", int'({err_a, ec_a}), 0);

    // 2: octave 2 (side 16), window clamped on both axes
    kp_mem_a[0] = kp(2, 15, 0, 0); kp_mem_a[1] = '0;
    expect_patch(12, 0, 2, 0, 0);  expect_patch(14, 0, 2, 0, 1);
    expect_patch(12, 2, 2, 0, 2);  expect_patch(14, 2, 2, 0, 3);
    run_pass_a(300, got);
    chk("t2_done_seen", got, 1);
    chk("t2_kp_processed", int'(kpp_a), 1);
    chk("t2_queues_empty", hq_a.size() + wq_a.size(), 0);

    // 3: bad octave and out-of-image keypoints are skipped
    kp_mem_a[0] = kp(3, 5, 5, 0);
    kp_mem_a[1] = kp(0, 63, 63, 0);
    kp_mem_a[2] = kp(1, 40, 3, 1);
    kp_mem_a[3] = kp(1, 31, 1, 1);
    kp_mem_a[4] = '0;
    expect_patch(60, 60, 0, 0, 0); expect_patch(62, 60, 0, 0, 1);
    expect_patch(60, 62, 0, 0, 2); expect_patch(62, 62, 0, 0, 3);
    expect_patch(28, 0, 1, 1, 4);  expect_patch(30, 0, 1, 1, 5);
    expect_patch(28, 2, 1, 1, 6);  expect_patch(30, 2, 1, 1, 7);
    run_pass_a(600, got);
    chk("t3_done_seen", got, 1);
    chk("t3_kp_skipped", int'(kps_a), 2);
    chk("t3_kp_processed", int'(kpp_a), 2);
    chk("t3_queues_empty", hq_a.size() + wq_a.size(), 0);

    // 4: six-entry descriptor BRAM, second keypoint overflows
    kp_mem_b[0] = kp(0, 10, 20, 1); kp_mem_b[1] = kp(0, 30, 30, 0); kp_mem_b[2] = '0;
    wb.data = {6'd8,  6'd18, 2'd0, 1'b1, 9'h15A}; wb.addr = 12'd0; wq_b.push_back(wb);
    wb.data = {6'd10, 6'd18, 2'd0, 1'b1, 9'h15A}; wb.addr = 12'd1; wq_b.push_back(wb);
    wb.data = {6'd8,  6'd20, 2'd0, 1'b1, 9'h15A}; wb.addr = 12'd2; wq_b.push_back(wb);
    wb.data = {6'd10, 6'd20, 2'd0, 1'b1, 9'h15A}; wb.addr = 12'd3; wq_b.push_back(wb);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    got = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      @(negedge clk);
      if (done_b) got = 1;
    end
    chk("t4_done_seen", got, 1);
    repeat (3) @(negedge clk);
    chk("t4_done_pulses", done_cnt_b, 1);
    chk("t4_error", int'(err_b), 1);
    chk("t4_error_code", int'(ec_b), 2);
    chk("t4_kp_processed", int'(kpp_b), 1);
    chk("t4_kp_skipped", int'(kps_b), 0);
    chk("t4_hist_requests", hs_cnt_b, 4);
    chk("t4_writes_left", wq_b.size(), 0);
    chk("t4_final_addr", int'(dwa_b), 4);
    chk("t4_busy", int'(busy_b), 0);

    // 5: histogram engine never answers
    kp_mem_a[0] = kp(0, 10, 20, 1); kp_mem_a[1] = '0;
    withhold = 1'b1;
    expect_hist(8, 18, 0, 1);
    d0 = done_cnt_a; w0 = wr_cnt_a;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    got = 0;
    for (int i = 0; i < 1300 && got == 0; i++) begin
      @(negedge clk);
      if (err_a) got = 1;
    end
    chk("t5_error_seen", got, 1);
    chk("t5_error_code", int'(ec_a), 1);
    repeat (50) @(negedge clk);
    chk("t5_busy_held", int'(busy_a), 1);
    chk("t5_error_held", int'({err_a, ec_a}), 5);
    chk("t5_no_done", done_cnt_a - d0, 0);
    chk("t5_no_write", wr_cnt_a - w0, 0);
    chk("t5_hist_left", hq_a.size(), 0);
    #2 rst_n = 1'b0;
    #1 chk_w("t5_reset_outputs", outs_a(), 128'd0);
    @(negedge clk); rst_n = 1'b1; withhold = 1'b0;
    repeat (2) @(negedge clk);

    // 6: reset while waiting, late hist_done must be ignored
    hlat = 12;
    kp_mem_a[0] = kp(0, 10, 20, 1); kp_mem_a[1] = '0;
    expect_hist(8, 18, 0, 1);
    w0 = wr_cnt_a;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && got == 0; i++) begin
      @(negedge clk);
      if (hs_a) got = 1;
    end
    chk("t6_request_seen", got, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("t6_busy_in_reset", int'(busy_a), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_no_write", wr_cnt_a - w0, 0);
    chk("t6_idle", int'(busy_a), 0);
    chk("t6_addr_zero", int'(dwa_a), 0);
    hlat = 3;
    expect_patch(8, 18, 0, 1, 0);  expect_patch(10, 18, 0, 1, 1);
    expect_patch(8, 20, 0, 1, 2);  expect_patch(10, 20, 0, 1, 3);
    run_pass_a(300, got);
    chk("t6_restart_done", got, 1);
    chk("t6_restart_queues", hq_a.size() + wq_a.size(), 0);
    chk("t6_kp_processed", int'(kpp_a), 1);

    // 7: every entry bad, pass ends at the last keypoint address
    fill_word = kp(3, 1, 1, 0);
    for (int i = 0; i < 16; i++) kp_mem_a[i] = fill_word;
    run_pass_a(5000, got);
    chk("t7_done_seen", got, 1);
    chk("t7_kp_skipped", int'(kps_a), 1000);
    chk("t7_kp_processed", int'(kpp_a), 0);
    chk("t7_last_addr", int'(kra_a), 999);
    chk("t7_error", int'(err_a), 0);
    chk("t7_queues_empty", hq_a.size() + wq_a.size(), 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
